// File: rtl/mux4_channel_scheduler_if.sv
// Handshake and mux-facing bundle between the four-channel scheduler and its neighbours.
// The slave modport is the scheduler side; master is the feeder/consumer side.
interface mux4_channel_scheduler_if #(
    parameter int WIDTH = 8
);
    logic [3:0]       in_valid;
    logic [3:0]       in_ready;
    logic [WIDTH-1:0] in_data0;
    logic [WIDTH-1:0] in_data1;
    logic [WIDTH-1:0] in_data2;
    logic [WIDTH-1:0] in_data3;
    logic [WIDTH-1:0] q0;
    logic [WIDTH-1:0] q1;
    logic [WIDTH-1:0] q2;
    logic [WIDTH-1:0] q3;
    logic             s1;
    logic             s0;
    logic             grant_valid;
    logic             grant_ready;
    logic [1:0]       grant_chan;

    modport master (
        output in_valid, in_data0, in_data1, in_data2, in_data3, grant_ready,
        input  in_ready, q0, q1, q2, q3, s1, s0, grant_valid, grant_chan
    );

    modport slave (
        input  in_valid, in_data0, in_data1, in_data2, in_data3, grant_ready,
        output in_ready, q0, q1, q2, q3, s1, s0, grant_valid, grant_chan
    );
endinterface

// File: rtl/mux4_channel_scheduler.sv
// Four one-entry channel buffers feeding mux4to1_8bit, with a round-robin
// grant FSM that drives the mux selects and a valid/ready grant handshake.
module mux4_channel_scheduler #(
    parameter int WIDTH = 8
) (
    input logic                     clk,
    input logic                     rst,
    mux4_channel_scheduler_if.slave bus
);
    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           state;
    logic [3:0]       full;
    logic [WIDTH-1:0] qr [4];
    logic [WIDTH-1:0] din [4];
    logic [1:0]       sel;
    logic [1:0]       last;
    logic             gv;

    logic [1:0]       pick;
    logic             pick_found;
    logic [1:0]       idx;

    assign din[0] = bus.in_data0;
    assign din[1] = bus.in_data1;
    assign din[2] = bus.in_data2;
    assign din[3] = bus.in_data3;

    // Search order last+1 .. last+4 (mod 4) so the last-served channel comes last.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        idx        = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!pick_found && full[idx]) begin
                pick       = idx;
                pick_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            full  <= '0;
            sel   <= '0;
            last  <= 2'd3;
            gv    <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                qr[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (bus.in_valid[i] && !full[i]) begin
                    qr[i]   <= din[i];
                    full[i] <= 1'b1;
                end
            end
            // Granted channel is always full, so its clear never collides with a write.
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        sel   <= pick;
                        gv    <= 1'b1;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (bus.grant_ready) begin
                        full[sel] <= 1'b0;
                        last      <= sel;
                        gv        <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = ~full;
    assign bus.q0          = qr[0];
    assign bus.q1          = qr[1];
    assign bus.q2          = qr[2];
    assign bus.q3          = qr[3];
    assign bus.s1          = sel[1];
    assign bus.s0          = sel[0];
    assign bus.grant_chan  = sel;
    assign bus.grant_valid = gv;
endmodule

// File: tb/tb_mux4_channel_scheduler.sv
// Scoreboard bench for mux4_channel_scheduler: expected grants are queued when
// bytes are written and checked against the mux output when each grant is accepted.
module tb_mux4_channel_scheduler;
    localparam int WIDTH = 8;

    typedef struct packed {
        logic [1:0]       chan;
        logic [WIDTH-1:0] data;
    } grant_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    grant_t sb[$];

    mux4_channel_scheduler_if #(.WIDTH(WIDTH)) bus ();

    mux4_channel_scheduler #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Behaviour of the downstream mux4to1_8bit driven by the scheduler outputs.
    function automatic logic [WIDTH-1:0] mux_f();
        case ({bus.s1, bus.s0})
            2'd0:    return bus.q0;
            2'd1:    return bus.q1;
            2'd2:    return bus.q2;
            default: return bus.q3;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        bus.in_valid    = '0;
        bus.grant_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic write_chans(input logic [3:0] mask, input logic [WIDTH-1:0] d0,
                               input logic [WIDTH-1:0] d1, input logic [WIDTH-1:0] d2,
                               input logic [WIDTH-1:0] d3);
        bus.in_valid = mask;
        bus.in_data0 = d0;
        bus.in_data1 = d1;
        bus.in_data2 = d2;
        bus.in_data3 = d3;
        tick();
        bus.in_valid = '0;
    endtask

    task automatic wait_drain(input int unsigned budget);
        int unsigned n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_left", 16'(sb.size()), 16'd0);
        sb.delete();
        tick();
    endtask

    always @(negedge clk) begin
        grant_t e;
        if (!rst && bus.grant_valid && bus.grant_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_grant", {14'd0, bus.grant_chan}, 16'hffff);
            end else begin
                e = sb.pop_front();
                check("grant_chan", {14'd0, bus.grant_chan}, {14'd0, e.chan});
                check("sel_bits", {14'd0, bus.s1, bus.s0}, {14'd0, e.chan});
                check("mux_f", {8'd0, mux_f()}, {8'd0, e.data});
            end
        end
    end

    initial begin
        bus.in_valid    = '0;
        bus.in_data0    = '0;
        bus.in_data1    = '0;
        bus.in_data2    = '0;
        bus.in_data3    = '0;
        bus.grant_ready = 1'b0;

        // Reset state
        do_reset();
        check("rst_in_ready", {12'd0, bus.in_ready}, 16'h000f);
        check("rst_grant_valid", {15'd0, bus.grant_valid}, 16'd0);
        check("rst_sel", {14'd0, bus.s1, bus.s0}, 16'd0);
        check("rst_q0", {8'd0, bus.q0}, 16'd0);
        check("rst_q1", {8'd0, bus.q1}, 16'd0);
        check("rst_q2", {8'd0, bus.q2}, 16'd0);
        check("rst_q3", {8'd0, bus.q3}, 16'd0);

        // Single channel, two-cycle write-to-grant latency
        bus.grant_ready = 1'b1;
        sb.push_back('{chan: 2'd2, data: 8'hf0});
        write_chans(4'b0100, 8'h00, 8'h00, 8'hf0, 8'h00);
        check("single_ready_busy", {12'd0, bus.in_ready}, 16'h000b);
        check("single_gv_early", {15'd0, bus.grant_valid}, 16'd0);
        tick();
        check("single_gv", {15'd0, bus.grant_valid}, 16'd1);
        check("single_q2", {8'd0, bus.q2}, 16'h00f0);
        check("single_ready_held", {12'd0, bus.in_ready}, 16'h000b);
        tick();
        check("single_gv_after", {15'd0, bus.grant_valid}, 16'd0);
        check("single_ready_after", {12'd0, bus.in_ready}, 16'h000f);
        check("single_drained", 16'(sb.size()), 16'd0);
        check("single_q2_kept", {8'd0, bus.q2}, 16'h00f0);

        // Round-robin across all four channels from reset priority
        do_reset();
        bus.grant_ready = 1'b1;
        sb.push_back('{chan: 2'd0, data: 8'h55});
        sb.push_back('{chan: 2'd1, data: 8'h0f});
        sb.push_back('{chan: 2'd2, data: 8'hf0});
        sb.push_back('{chan: 2'd3, data: 8'hff});
        write_chans(4'b1111, 8'h55, 8'h0f, 8'hf0, 8'hff);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("rr_bubble", {15'd0, bus.grant_valid}, 16'(k % 2));
        end
        check("rr_all_granted", 16'(sb.size()), 16'd0);
        check("rr_ready", {12'd0, bus.in_ready}, 16'h000f);

        // Backpressure holds the grant and ignores writes to the full buffer
        do_reset();
        sb.push_back('{chan: 2'd1, data: 8'h3c});
        write_chans(4'b0010, 8'h00, 8'h3c, 8'h00, 8'h00);
        tick();
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 4'b0010;
            bus.in_data1 = 8'haa;
            tick();
            check("bp_gv", {15'd0, bus.grant_valid}, 16'd1);
            check("bp_chan", {14'd0, bus.grant_chan}, 16'd1);
            check("bp_q1", {8'd0, bus.q1}, 16'h003c);
        end
        bus.in_valid    = '0;
        bus.grant_ready = 1'b1;
        wait_drain(20);
        check("bp_ready_after", {12'd0, bus.in_ready}, 16'h000f);

        // Fairness: after serving channel 2, channel 3 beats channel 0
        do_reset();
        bus.grant_ready = 1'b1;
        sb.push_back('{chan: 2'd2, data: 8'h22});
        write_chans(4'b0100, 8'h00, 8'h00, 8'h22, 8'h00);
        wait_drain(20);
        sb.push_back('{chan: 2'd3, data: 8'h33});
        sb.push_back('{chan: 2'd0, data: 8'h11});
        write_chans(4'b1001, 8'h11, 8'h00, 8'h00, 8'h33);
        wait_drain(20);

        // Reset mid-grant discards buffers and restores channel 0 priority
        do_reset();
        write_chans(4'b1000, 8'h00, 8'h00, 8'h00, 8'h77);
        tick();
        check("mid_gv", {15'd0, bus.grant_valid}, 16'd1);
        check("mid_chan", {14'd0, bus.grant_chan}, 16'd3);
        write_chans(4'b0010, 8'h00, 8'h99, 8'h00, 8'h00);
        bus.grant_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_gv", {15'd0, bus.grant_valid}, 16'd0);
        check("mid_rst_ready", {12'd0, bus.in_ready}, 16'h000f);
        check("mid_rst_q3", {8'd0, bus.q3}, 16'd0);
        check("mid_rst_q1", {8'd0, bus.q1}, 16'd0);
        sb.push_back('{chan: 2'd0, data: 8'ha0});
        sb.push_back('{chan: 2'd1, data: 8'ha1});
        sb.push_back('{chan: 2'd3, data: 8'ha3});
        write_chans(4'b1011, 8'ha0, 8'ha1, 8'h00, 8'ha3);
        wait_drain(40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
